// File: rtl/lsu_axi_split.sv
// Purpose : load/store unit bridging the EXU result stage to an AXI4-Lite master port;
//           misaligned accesses that straddle a DATA_W boundary are split into two aligned beats.
// Latency : zero-wait slave -> resp_valid 3 cycles after acceptance (one beat), 5 cycles (split).
// Backpr. : req_ready only in IDLE; each bus valid holds (with stable payload) until its ready.
// Ports   : clk/rst_n (sync, active-low); req_* request in; resp_* one-cycle completion pulse;
//           aw/w/b and ar/r AXI4-Lite master channels (never active together).
module lsu_axi_split #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_wen,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [1:0]          req_size,
   input  logic                req_unsigned,
   output logic                resp_valid,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_err,
   output logic                awvalid,
   input  logic                awready,
   output logic [ADDR_W-1:0]   awaddr,
   output logic                wvalid,
   input  logic                wready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   input  logic                bvalid,
   output logic                bready,
   input  logic [1:0]          bresp,
   output logic                arvalid,
   input  logic                arready,
   output logic [ADDR_W-1:0]   araddr,
   input  logic                rvalid,
   output logic                rready,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp
);

   localparam int BYTES   = DATA_W / 8;
   localparam int OFF_W   = $clog2(BYTES);
   localparam int WIN_W   = 2 * DATA_W;
   localparam int STRB2_W = 2 * BYTES;

   typedef enum logic [3:0] {
      S_IDLE, S_AR0, S_R0, S_AR1, S_R1, S_AW0, S_B0, S_AW1, S_B1, S_RESP
   } state_t;

   state_t state, state_nx;

   logic [ADDR_W-1:0]  base_q;
   logic [OFF_W-1:0]   off_q;
   logic [1:0]         size_q;
   logic               uns_q;
   logic               wen_q;
   logic               split_q;
   logic               err_q;
   logic [WIN_W-1:0]   data2_q;
   logic [STRB2_W-1:0] strb2_q;
   logic [DATA_W-1:0]  beat0_q;
   logic [DATA_W-1:0]  beat1_q;
   logic               aw_done_q;
   logic               w_done_q;

   // Request decode, evaluated combinationally and captured at acceptance.
   logic [OFF_W-1:0]   req_off;
   logic [3:0]         req_n;
   logic               req_split;
   logic               req_illegal;
   logic [STRB2_W-1:0] req_strb_mask;

   assign req_off       = req_addr[OFF_W-1:0];
   assign req_n         = 4'd1 << req_size;
   assign req_split     = (5'(req_off) + 5'(req_n)) > 5'(BYTES);
   assign req_illegal   = (req_size == 2'd3) && (DATA_W != 64);
   assign req_strb_mask = STRB2_W'((16'h1 << req_n) - 16'h1);

   // AW and W complete independently; the beat is done once both have fired,
   // whether in the same cycle or in different ones.
   logic aw_fire, w_fire, both_done;
   assign aw_fire   = !aw_done_q && awready;
   assign w_fire    = !w_done_q && wready;
   assign both_done = (aw_done_q || aw_fire) && (w_done_q || w_fire);

   // Load data: little-endian window {beat1,beat0} shifted down by the byte offset,
   // then truncated to the access size and extended.
   logic [DATA_W-1:0] raw, ext;
   assign raw = DATA_W'({beat1_q, beat0_q} >> {off_q, 3'b000});

   always_comb begin
      ext = raw;
      case (size_q)
         2'd0: ext = uns_q ? DATA_W'(raw[7:0])  : DATA_W'($signed(raw[7:0]));
         2'd1: ext = uns_q ? DATA_W'(raw[15:0]) : DATA_W'($signed(raw[15:0]));
         2'd2: ext = uns_q ? DATA_W'(raw[31:0]) : DATA_W'($signed(raw[31:0]));
         default: ext = raw;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      req_ready  = 1'b0;
      arvalid    = 1'b0;
      araddr     = '0;
      rready     = 1'b0;
      awvalid    = 1'b0;
      awaddr     = '0;
      wvalid     = 1'b0;
      wdata      = '0;
      wstrb      = '0;
      bready     = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_err   = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid)
               state_nx = req_illegal ? S_RESP : (req_wen ? S_AW0 : S_AR0);
         end
         S_AR0: begin
            arvalid = 1'b1;
            araddr  = base_q;
            if (arready) state_nx = S_R0;
         end
         S_R0: begin
            rready = 1'b1;
            // An error on the first beat skips the second one.
            if (rvalid) state_nx = (rresp != 2'd0 || !split_q) ? S_RESP : S_AR1;
         end
         S_AR1: begin
            arvalid = 1'b1;
            araddr  = base_q + ADDR_W'(BYTES);
            if (arready) state_nx = S_R1;
         end
         S_R1: begin
            rready = 1'b1;
            if (rvalid) state_nx = S_RESP;
         end
         S_AW0: begin
            awvalid = !aw_done_q;
            wvalid  = !w_done_q;
            awaddr  = base_q;
            wdata   = data2_q[DATA_W-1:0];
            wstrb   = strb2_q[BYTES-1:0];
            if (both_done) state_nx = S_B0;
         end
         S_B0: begin
            bready = 1'b1;
            if (bvalid) state_nx = (bresp != 2'd0 || !split_q) ? S_RESP : S_AW1;
         end
         S_AW1: begin
            awvalid = !aw_done_q;
            wvalid  = !w_done_q;
            awaddr  = base_q + ADDR_W'(BYTES);
            wdata   = data2_q[WIN_W-1:DATA_W];
            wstrb   = strb2_q[STRB2_W-1:BYTES];
            if (both_done) state_nx = S_B1;
         end
         S_B1: begin
            bready = 1'b1;
            if (bvalid) state_nx = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            resp_rdata = (!err_q && !wen_q) ? ext : '0;
            state_nx   = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         base_q    <= '0;
         off_q     <= '0;
         size_q    <= '0;
         uns_q     <= 1'b0;
         wen_q     <= 1'b0;
         split_q   <= 1'b0;
         err_q     <= 1'b0;
         data2_q   <= '0;
         strb2_q   <= '0;
         beat0_q   <= '0;
         beat1_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (req_valid) begin
               base_q    <= req_addr & ~ADDR_W'(BYTES - 1);
               off_q     <= req_off;
               size_q    <= req_size;
               uns_q     <= req_unsigned;
               wen_q     <= req_wen;
               split_q   <= req_split;
               err_q     <= req_illegal;
               data2_q   <= {{DATA_W{1'b0}}, req_wdata} << {req_off, 3'b000};
               strb2_q   <= req_strb_mask << req_off;
               beat0_q   <= '0;
               // Kept zero for single-beat loads so the window's upper half is inert.
               beat1_q   <= '0;
               aw_done_q <= 1'b0;
               w_done_q  <= 1'b0;
            end
            S_R0: if (rvalid) begin
               beat0_q <= rdata;
               if (rresp != 2'd0) err_q <= 1'b1;
            end
            S_R1: if (rvalid) begin
               beat1_q <= rdata;
               if (rresp != 2'd0) err_q <= 1'b1;
            end
            S_AW0, S_AW1: begin
               if (both_done) begin
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
               end else begin
                  if (aw_fire) aw_done_q <= 1'b1;
                  if (w_fire)  w_done_q  <= 1'b1;
               end
            end
            S_B0, S_B1: if (bvalid && bresp != 2'd0) err_q <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_axi_split.sv
// Purpose : directed bench for lsu_axi_split (DATA_W=32) with a small reactive AXI4-Lite slave.
// Latency : measured as the negedge count after the acceptance edge at which resp_valid is seen.
// Backpr. : slave awready/wready delays programmable via aw_wait/w_wait; AR/R and B are zero-wait.
module tb_lsu_axi_split;
   localparam int DW = 32;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid, req_ready, req_wen, req_unsigned;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [1:0]    req_size;
   logic          resp_valid, resp_err;
   logic [DW-1:0] resp_rdata;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic [AW-1:0] awaddr, araddr;
   logic [DW-1:0] wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;
   logic          arvalid, arready, rvalid, rready;

   always #5 clk = ~clk;

   lsu_axi_split #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .req_unsigned(req_unsigned),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
   );

   // ---------------- slave model ----------------
   logic [31:0] rd_data [64];
   logic [1:0]  rd_resp [64];
   logic [31:0] ar_log [64];
   logic [31:0] aw_log [64];
   logic [31:0] wd_log [64];
   logic [3:0]  ws_log [64];
   int ar_n = 0, aw_n = 0, w_n = 0, b_n = 0;
   int aw_wait = 0, w_wait = 0, aw_age = 0, w_age = 0, stab_err = 0;
   logic got_aw = 1'b0, got_w = 1'b0, aw_hold = 1'b0;
   logic [31:0] aw_prev = '0;
   logic aw_now, w_now;

   assign arready = 1'b1;
   assign awready = (aw_age >= aw_wait);
   assign wready  = (w_age >= w_wait);
   assign bresp   = 2'd0;
   assign aw_now  = awvalid && awready;
   assign w_now   = wvalid && wready;

   always @(posedge clk) begin
      if (!rst_n) begin
         rvalid  <= 1'b0;
         rdata   <= '0;
         rresp   <= '0;
         bvalid  <= 1'b0;
         aw_age  <= 0;
         w_age   <= 0;
         got_aw  <= 1'b0;
         got_w   <= 1'b0;
         aw_hold <= 1'b0;
      end else begin
         if (arvalid && arready) begin
            ar_log[ar_n] <= araddr;
            ar_n  <= ar_n + 1;
            rvalid <= 1'b1;
            rdata  <= rd_data[ar_n];
            rresp  <= rd_resp[ar_n];
         end else if (rvalid && rready) begin
            rvalid <= 1'b0;
         end
         if (aw_hold && awvalid && awaddr != aw_prev) stab_err <= stab_err + 1;
         aw_hold <= awvalid && !awready;
         aw_prev <= awaddr;
         if (aw_now) begin
            aw_log[aw_n] <= awaddr;
            aw_n   <= aw_n + 1;
            aw_age <= 0;
         end else if (awvalid) begin
            aw_age <= aw_age + 1;
         end
         if (w_now) begin
            wd_log[w_n] <= wdata;
            ws_log[w_n] <= wstrb;
            w_n   <= w_n + 1;
            w_age <= 0;
         end else if (wvalid) begin
            w_age <= w_age + 1;
         end
         if (bvalid && bready) begin
            bvalid <= 1'b0;
            b_n    <= b_n + 1;
         end
         if ((got_aw || aw_now) && (got_w || w_now)) begin
            bvalid <= 1'b1;
            got_aw <= 1'b0;
            got_w  <= 1'b0;
         end else begin
            if (aw_now) got_aw <= 1'b1;
            if (w_now)  got_w  <= 1'b1;
         end
      end
   end

   // ---------------- checking ----------------
   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input logic uns,
                         output int lat, output logic [31:0] rd, output logic er);
      lat = 0;
      rd  = '0;
      er  = 1'b0;
      @(negedge clk);
      chk("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_wen = wen; req_addr = addr;
      req_wdata = wd; req_size = sz; req_unsigned = uns;
      @(posedge clk);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (resp_valid) begin
            lat = k;
            rd  = resp_rdata;
            er  = resp_err;
            break;
         end
      end
      chk("resp_seen", lat != 0, 1);
      @(negedge clk);
      chk("resp_pulse_one", resp_valid, 0);
      chk("req_ready_back", req_ready, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int lat;
      logic [31:0] rd;
      logic er;
      int a0, s0, w0, b0;

      req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
      req_size = '0; req_unsigned = 1'b0;
      for (int i = 0; i < 64; i++) begin
         rd_data[i] = '0;
         rd_resp[i] = '0;
      end

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_err}, 0);
      chk("rst_addr_strb", {araddr, awaddr, wstrb}, 0);
      chk("rst_rdata", resp_rdata, 0);
      rst_n = 1'b1;

      // Aligned LW
      a0 = ar_n; rd_data[a0] = 32'hDEADBEEF;
      do_req(1'b0, 32'h80000010, 0, 2'd2, 1'b0, lat, rd, er);
      chk("lw_ar_cnt", ar_n - a0, 1);
      chk("lw_araddr", ar_log[a0], 32'h80000010);
      chk("lw_rdata", rd, 32'hDEADBEEF);
      chk("lw_err", er, 0);
      chk("lw_lat", lat, 3);

      // LH signed, split across the word boundary
      a0 = ar_n; rd_data[a0] = 32'h11223344; rd_data[a0+1] = 32'hAABBCC80;
      do_req(1'b0, 32'h80000013, 0, 2'd1, 1'b0, lat, rd, er);
      chk("lh_split_ar_cnt", ar_n - a0, 2);
      chk("lh_split_ar0", ar_log[a0], 32'h80000010);
      chk("lh_split_ar1", ar_log[a0+1], 32'h80000014);
      chk("lh_split_rdata", rd, 32'hFFFF8011);
      chk("lh_split_lat", lat, 5);

      // LHU upper half, no split
      a0 = ar_n; rd_data[a0] = 32'h87654321;
      do_req(1'b0, 32'h80000002, 0, 2'd1, 1'b1, lat, rd, er);
      chk("lhu_ar_cnt", ar_n - a0, 1);
      chk("lhu_rdata", rd, 32'h00008765);

      // LB signed, top byte
      a0 = ar_n; rd_data[a0] = 32'h9A000000;
      do_req(1'b0, 32'h80000003, 0, 2'd0, 1'b0, lat, rd, er);
      chk("lb_rdata", rd, 32'hFFFFFF9A);
      chk("lb_lat", lat, 3);

      // SW split
      a0 = ar_n; s0 = aw_n; w0 = w_n;
      do_req(1'b1, 32'h80000022, 32'hCAFEBABE, 2'd2, 1'b0, lat, rd, er);
      chk("sw_aw_cnt", aw_n - s0, 2);
      chk("sw_aw0", aw_log[s0], 32'h80000020);
      chk("sw_aw1", aw_log[s0+1], 32'h80000024);
      chk("sw_strb0", ws_log[w0], 4'b1100);
      chk("sw_strb1", ws_log[w0+1], 4'b0011);
      chk("sw_data0", wd_log[w0] & 32'hFFFF0000, 32'hBABE0000);
      chk("sw_data1", wd_log[w0+1] & 32'h0000FFFF, 32'h0000CAFE);
      chk("sw_no_read", ar_n - a0, 0);
      chk("sw_resp", {er, rd}, 0);
      chk("sw_lat", lat, 5);

      // SB single beat
      s0 = aw_n; w0 = w_n;
      do_req(1'b1, 32'h80000001, 32'h0000005A, 2'd0, 1'b0, lat, rd, er);
      chk("sb_aw_cnt", aw_n - s0, 1);
      chk("sb_awaddr", aw_log[s0], 32'h80000000);
      chk("sb_strb", ws_log[w0], 4'b0010);
      chk("sb_byte", (wd_log[w0] >> 8) & 32'hFF, 32'h5A);
      chk("sb_lat", lat, 3);

      // Split load, error on beat0: second AR suppressed
      a0 = ar_n; rd_data[a0] = 32'h12345678; rd_resp[a0] = 2'd2;
      do_req(1'b0, 32'h80000006, 0, 2'd2, 1'b0, lat, rd, er);
      chk("err0_ar_cnt", ar_n - a0, 1);
      chk("err0_err", er, 1);
      chk("err0_rdata", rd, 0);
      chk("err0_lat", lat, 3);

      // Split load, error on beat1
      a0 = ar_n; rd_data[a0] = 32'h11111111; rd_data[a0+1] = 32'h22222222; rd_resp[a0+1] = 2'd2;
      do_req(1'b0, 32'h80000005, 0, 2'd2, 1'b0, lat, rd, er);
      chk("err1_ar_cnt", ar_n - a0, 2);
      chk("err1_err", er, 1);
      chk("err1_rdata", rd, 0);

      // SD on a 32-bit bus: illegal, no bus traffic
      a0 = ar_n; s0 = aw_n;
      do_req(1'b1, 32'h80000008, 32'h01234567, 2'd3, 1'b0, lat, rd, er);
      chk("sd_err", er, 1);
      chk("sd_no_bus", (ar_n - a0) + (aw_n - s0), 0);
      chk("sd_lat", lat, 1);

      // awready three cycles after wready
      aw_wait = 3; s0 = aw_n; w0 = w_n; b0 = b_n;
      do_req(1'b1, 32'h80000040, 32'h01020304, 2'd2, 1'b0, lat, rd, er);
      aw_wait = 0;
      chk("awdly_stable", stab_err, 0);
      chk("awdly_aw_cnt", aw_n - s0, 1);
      chk("awdly_awaddr", aw_log[s0], 32'h80000040);
      chk("awdly_strb", ws_log[w0], 4'hF);
      chk("awdly_b_cnt", b_n - b0, 1);
      chk("awdly_lat", lat, 6);

      // Reset while waiting in R0
      @(negedge clk);
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h80000050; req_size = 2'd2;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (rready) break;
         @(negedge clk);
      end
      chk("r0_reached", rready, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("r0rst_valids", {arvalid, awvalid, wvalid, rready, bready, resp_valid}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("r0rst_req_ready", req_ready, 1);

      // Recovery after reset
      a0 = ar_n; rd_data[a0] = 32'h0BADF00D;
      do_req(1'b0, 32'h80000060, 0, 2'd2, 1'b0, lat, rd, er);
      chk("recover_rdata", rd, 32'h0BADF00D);
      chk("recover_araddr", ar_log[a0], 32'h80000060);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
